// File: rtl/serial_subtractor_8bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_8bit
// Description : Bit-serial subtractor, diff = a - b, one bit per clock,
//               LSB first, with a start/busy/done handshake. Produces the
//               unsigned borrow and the two's-complement overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_sr;
  logic               r_br;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_amsb;
  logic               r_bmsb;

  logic               w_d;
  logic               w_br_nxt;
  logic [WIDTH-1:0]   w_sr_nxt;

  // One full-subtractor slice operating on the current LSBs and borrow.
  assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_sr_nxt = {w_d, r_sr[WIDTH-1:1]};

  // Control FSM, operand/result shifting and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            // Operand MSBs shift out during the run, so keep them for ovf.
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            // The final bit is this cycle's d, so it is also the diff MSB.
            diff    <= w_sr_nxt;
            borrow  <= w_br_nxt;
            ovf     <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor_8bit
// Description : Self-checking bench for serial_subtractor_8bit: directed
//               vector table, start-while-busy, back-to-back, mid-run reset
//               and random operations against a reference subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_8bit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] ediff;
    logic       eborrow;
    logic       eovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one operation (accepted on the next rising edge), optionally pulse
  // start again 'inj' cycles into the run, then wait for done and check.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input int inj, input string nm);
    int n;
    int busy_err;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_v;
    chk({nm, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    n        = 0;
    busy_err = 0;
    while (!done && n < 20) begin
      if (n == inj) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && !busy) busy_err++;
    end
    start = 1'b0;
    chk({nm, " latency"}, n, WIDTH);
    chk({nm, " busy_during_run"}, busy_err, 0);
    chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({nm, " diff"}, {24'd0, diff}, {24'd0, ed});
    chk({nm, " borrow"}, {31'd0, borrow}, {31'd0, eb});
    chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  task automatic idle_cycles(input int k, input logic [7:0] held, input string nm);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " idle_done"}, {31'd0, done}, 32'd0);
      chk({nm, " idle_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, " idle_diff_held"}, {24'd0, diff}, {24'd0, held});
    end
  endtask

  initial begin
    logic [8:0] m;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       mo;
    int         gap;

    vecs[0]  = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1]  = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[2]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[7]  = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[8]  = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    vecs[9]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{8'hC3, 8'h5A, 8'h69, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset diff", {24'd0, diff}, 32'd0);
    chk("reset borrow", {31'd0, borrow}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    // Directed table, with one idle cycle between operations.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ediff, vecs[i].eborrow,
             vecs[i].eovf, -1, $sformatf("vec%0d", i));
      idle_cycles(1, vecs[i].ediff, $sformatf("vec%0d", i));
    end

    // Start pulsed during RUN is ignored; then back-to-back start in DONE.
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 2, "ignore_start");
    run_op(8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, -1, "back_to_back");
    @(posedge clk);
    #1;
    chk("b2b single_done", {31'd0, done}, 32'd0);

    // Reset mid-run discards the operation and clears the outputs.
    @(negedge clk);
    a     = 8'h44;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst diff", {24'd0, diff}, 32'd0);
    chk("midrst borrow", {31'd0, borrow}, 32'd0);
    chk("midrst ovf", {31'd0, ovf}, 32'd0);
    idle_cycles(WIDTH + 2, 8'h00, "midrst");
    run_op(8'h44, 8'h01, 8'h43, 1'b0, 1'b0, -1, "after_rst");

    // Random operations with random gaps (zero gap = back-to-back).
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      m   = {1'b0, ra} - {1'b0, rb};
      mo  = (ra[7] != rb[7]) && (m[7] != ra[7]);
      run_op(ra, rb, m[7:0], m[8], mo, -1, $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_cycles(gap, m[7:0], $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
